instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the instruction fetch stage and the instruction memory. It takes the fetch PC and returns the 32-bit instruction on a hit in the same cycle. On a miss it raises `busywait`, which drives the fetch stage's `instruction_mem_busywait`, and refills one 128-bit block from memory. Only fetch reads go through it; there is no write path.

---
 rtl/instruction_cache.sv | 123 ++++++++++++
 tb/tb_instruction_cache.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache that sits
// between the fetch stage and instruction memory. A hit returns the word
// in the same cycle. A miss stalls fetch and refills one 128-bit block.
//
// Ports:
//   CLK, RESET      clock; asynchronous active-high reset
//   PC              byte fetch address
//   INSTRUCTION     fetched instruction
//   busywait        stall to fetch (instruction_mem_busywait)
//   mem_read        block read request to instruction memory
//   mem_address     block address (latched miss PC[31:4])
//   mem_readdata    refill block; word n at bits [32n+31:32n]
//   mem_busywait    memory busy; data valid while low with mem_read high
module instruction_cache #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 28 - INDEX_BITS;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] NO_REQ   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t state, state_next;

  logic [LINES-1:0]    line_valid;
  logic [TAG_BITS-1:0] line_tag  [LINES];
  logic [127:0]        line_data [LINES];

  logic [27:0]  miss_addr;
  logic [127:0] refill_buf;
  logic [31:0]  last_hit;

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [6:0]            word_offset;
  logic [127:0]          cur_line;
  logic [31:0]           cur_word;
  logic                  no_req;
  logic                  hit;
  logic                  lookup_miss;

  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;

  // Lookup
  always_comb begin
    pc_index    = PC[4 +: INDEX_BITS];
    pc_tag      = PC[31 -: TAG_BITS];
    word_offset = {PC[3:2], 5'b0};
    cur_line    = line_data[pc_index];
    cur_word    = cur_line[word_offset +: 32];
    no_req      = (PC == NO_REQ);
    hit         = (state == IDLE) && !no_req && line_valid[pc_index]
                  && (line_tag[pc_index] == pc_tag);
    lookup_miss = (state == IDLE) && !no_req && !hit;
    fill_index  = miss_addr[INDEX_BITS-1:0];
    fill_tag    = miss_addr[27 -: TAG_BITS];
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (lookup_miss)   state_next = MEM_READ;
      MEM_READ: if (!mem_busywait) state_next = UPDATE;
      UPDATE:                      state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_read    = (state == MEM_READ);
    mem_address = miss_addr;
    busywait    = (state != IDLE) || lookup_miss;
    if (no_req)   INSTRUCTION = NOP;
    else if (hit) INSTRUCTION = cur_word;
    else          INSTRUCTION = last_hit;
  end

  // Miss address, refill buffer, last hit word and valid bits; an abort by
  // reset discards the buffer, and the line is only installed from UPDATE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss_addr  <= '0;
      refill_buf <= '0;
      last_hit   <= NOP;
      line_valid <= '0;
    end else begin
      if (lookup_miss) miss_addr <= PC[31:4];
      if (state == MEM_READ && !mem_busywait) refill_buf <= mem_readdata;
      if (hit) last_hit <= cur_word;
      if (state == UPDATE) line_valid[fill_index] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= refill_buf;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int tests;
  int fails;

  instruction_cache #(.INDEX_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [127:0] BLK0  = 128'h00300093_00200093_00100093_00000013;
  localparam logic [127:0] BLK80 = 128'h0800_0333_0800_0222_0800_0111_0800_0000;
  localparam logic [127:0] BLK10 = 128'h1000_0D0D_1000_0C0C_1000_0B0B_1000_0A0A;
  localparam logic [127:0] BLK20 = 128'h2000_0004_2000_0003_2000_0002_2000_0001;
  localparam logic [127:0] BLK40 = 128'h4000_0004_4000_0003_4000_0002_4000_0001;

  // Memory-side driver: presents pc, moves PC to pc_mid in the first
  // MEM_READ cycle, holds mem_busywait high for lat read cycles, then returns
  // blk. Stops one edge after mem_read falls. Returns observations only.
  task automatic do_refill(input logic [31:0] pc, input logic [31:0] pc_mid,
                           input int lat, input logic [127:0] blk,
                           output int edges, output int rd_cycles,
                           output logic [27:0] seen_addr,
                           output bit addr_changed, output bit timeout);
    bit done;
    PC = pc;
    mem_busywait = 1'b1;
    edges = 0;
    rd_cycles = 0;
    seen_addr = '0;
    addr_changed = 1'b0;
    done = 1'b0;
    while (!done && edges < 100) begin
      @(posedge CLK); #1;
      edges++;
      if (mem_read) begin
        rd_cycles++;
        if (rd_cycles == 1) begin
          seen_addr = mem_address;
          PC = pc_mid;
        end else if (mem_address !== seen_addr) begin
          addr_changed = 1'b1;
        end
        if (rd_cycles > lat) begin
          mem_busywait = 1'b0;
          mem_readdata = blk;
        end else begin
          mem_busywait = 1'b1;
          mem_readdata = {4{$urandom()}};
        end
      end else begin
        mem_busywait = 1'b1;
        mem_readdata = {4{$urandom()}};
        if (rd_cycles > 0) begin
          @(posedge CLK); #1;
          edges++;
          done = 1'b1;
        end
      end
    end
    timeout = !done;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    PC = 32'hFFFF_FFFC;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    #2;
    tests++;
    if (busywait !== 1'b0 || INSTRUCTION !== 32'h0000_0013) begin
      fails++;
      $display("FAIL reset_noreq: busywait=%b INSTRUCTION=%h required 0/00000013", busywait, INSTRUCTION);
    end
    tests++;
    if (mem_read !== 1'b0 || mem_address !== 28'h0) begin
      fails++;
      $display("FAIL reset_mem: mem_read=%b mem_address=%h required 0/0000000", mem_read, mem_address);
    end
    PC = 32'h0000_0000;
    #1;
    tests++;
    if (busywait !== 1'b1) begin
      fails++;
      $display("FAIL reset_miss_busy: busywait=%b required 1", busywait);
    end
    @(posedge CLK); #1;
    PC = 32'hFFFF_FFFC;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      tests++;
      if (mem_read !== 1'b0 || busywait !== 1'b0 || INSTRUCTION !== 32'h0000_0013) begin
        fails++;
        $display("FAIL noreq_idle: mem_read=%b busywait=%b INSTRUCTION=%h required 0/0/00000013",
                 mem_read, busywait, INSTRUCTION);
      end
    end
  endtask

  task automatic test_cold_miss();
    int edges, rd;
    logic [27:0] addr;
    bit chg, to;
    PC = 32'h0;
    #1;
    tests++;
    if (busywait !== 1'b1 || mem_read !== 1'b0) begin
      fails++;
      $display("FAIL cold_detect: busywait=%b mem_read=%b required 1/0", busywait, mem_read);
    end
    do_refill(32'h0, 32'h0, 4, BLK0, edges, rd, addr, chg, to);
    tests++;
    if (to || edges !== 7 || busywait !== 1'b0) begin
      fails++;
      $display("FAIL cold_latency: edges=%0d busywait=%b timeout=%b required 7/0/0", edges, busywait, to);
    end
    tests++;
    if (rd !== 5 || addr !== 28'h0 || chg) begin
      fails++;
      $display("FAIL cold_memread: cycles=%0d addr=%h changed=%b required 5/0000000/0", rd, addr, chg);
    end
    tests++;
    if (INSTRUCTION !== 32'h0000_0013) begin
      fails++;
      $display("FAIL cold_data: INSTRUCTION=%h required 00000013", INSTRUCTION);
    end
  endtask

  task automatic test_hits();
    logic [31:0] pcs [3];
    logic [31:0] exp [3];
    pcs = '{32'h4, 32'h8, 32'hC};
    exp = '{32'h0010_0093, 32'h0020_0093, 32'h0030_0093};
    for (int i = 0; i < 3; i++) begin
      PC = pcs[i];
      #1;
      tests++;
      if (INSTRUCTION !== exp[i] || busywait !== 1'b0) begin
        fails++;
        $display("FAIL hit_%0d: INSTRUCTION=%h busywait=%b required %h/0", i, INSTRUCTION, busywait, exp[i]);
      end
      @(posedge CLK); #1;
      tests++;
      if (mem_read !== 1'b0 || busywait !== 1'b0) begin
        fails++;
        $display("FAIL hit_nomem_%0d: mem_read=%b busywait=%b required 0/0", i, mem_read, busywait);
      end
    end
    // Byte-offset bits are ignored
    PC = 32'h0000_0007;
    #1;
    tests++;
    if (INSTRUCTION !== 32'h0010_0093 || busywait !== 1'b0) begin
      fails++;
      $display("FAIL hit_byteoff: INSTRUCTION=%h busywait=%b required 00100093/0", INSTRUCTION, busywait);
    end
  endtask

  task automatic test_conflict();
    int edges, rd;
    logic [27:0] addr;
    bit chg, to;
    do_refill(32'h80, 32'h80, 1, BLK80, edges, rd, addr, chg, to);
    tests++;
    if (to || addr !== 28'h000_0008 || rd !== 2 || edges !== 4) begin
      fails++;
      $display("FAIL conflict_refill: addr=%h cycles=%0d edges=%0d timeout=%b required 0000008/2/4/0",
               addr, rd, edges, to);
    end
    tests++;
    if (busywait !== 1'b0 || INSTRUCTION !== 32'h0800_0000) begin
      fails++;
      $display("FAIL conflict_hit: INSTRUCTION=%h busywait=%b required 08000000/0", INSTRUCTION, busywait);
    end
    PC = 32'h0;
    #1;
    tests++;
    if (busywait !== 1'b1) begin
      fails++;
      $display("FAIL conflict_evicted: busywait=%b required 1", busywait);
    end
    // Reinstall line 0 with zero memory wait (3-edge penalty)
    do_refill(32'h0, 32'h0, 0, BLK0, edges, rd, addr, chg, to);
    tests++;
    if (to || edges !== 3 || rd !== 1 || busywait !== 1'b0 || INSTRUCTION !== 32'h0000_0013) begin
      fails++;
      $display("FAIL refill_m0: edges=%0d cycles=%0d busywait=%b INSTRUCTION=%h required 3/1/0/00000013",
               edges, rd, busywait, INSTRUCTION);
    end
    PC = 32'h80;
    #1;
    tests++;
    if (busywait !== 1'b1) begin
      fails++;
      $display("FAIL conflict_back: busywait=%b required 1", busywait);
    end
  endtask

  task automatic test_reset_mid_refill();
    int edges, rd;
    logic [27:0] addr;
    bit chg, to;
    @(negedge CLK);
    PC = 32'h10;
    mem_busywait = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 28'h000_0001) begin
      fails++;
      $display("FAIL abort_pre: mem_read=%b mem_address=%h required 1/0000001", mem_read, mem_address);
    end
    RESET = 1'b1;
    #1;
    tests++;
    if (mem_read !== 1'b0 || mem_address !== 28'h0) begin
      fails++;
      $display("FAIL abort_drop: mem_read=%b mem_address=%h required 0/0000000", mem_read, mem_address);
    end
    // Late data arriving during/after the abort must be ignored
    mem_busywait = 1'b0;
    mem_readdata = BLK10;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    mem_busywait = 1'b1;
    PC = 32'h10;
    #1;
    tests++;
    if (busywait !== 1'b1) begin
      fails++;
      $display("FAIL abort_notinstalled: busywait=%b required 1", busywait);
    end
    do_refill(32'h10, 32'h10, 2, BLK10, edges, rd, addr, chg, to);
    tests++;
    if (to || edges !== 5 || addr !== 28'h000_0001 || busywait !== 1'b0
        || INSTRUCTION !== 32'h1000_0A0A) begin
      fails++;
      $display("FAIL abort_retry: edges=%0d addr=%h busywait=%b INSTRUCTION=%h required 5/0000001/0/10000a0a",
               edges, addr, busywait, INSTRUCTION);
    end
  endtask

  task automatic test_pc_change();
    int edges, rd;
    logic [27:0] addr;
    bit chg, to;
    do_refill(32'h20, 32'h40, 2, BLK20, edges, rd, addr, chg, to);
    tests++;
    if (to || addr !== 28'h000_0002 || chg || rd !== 3) begin
      fails++;
      $display("FAIL pcchg_addr: addr=%h changed=%b cycles=%0d timeout=%b required 0000002/0/3/0",
               addr, chg, rd, to);
    end
    tests++;
    if (busywait !== 1'b1) begin
      fails++;
      $display("FAIL pcchg_newmiss: busywait=%b required 1", busywait);
    end
    @(posedge CLK); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 28'h000_0004) begin
      fails++;
      $display("FAIL pcchg_second: mem_read=%b mem_address=%h required 1/0000004", mem_read, mem_address);
    end
    mem_busywait = 1'b0;
    mem_readdata = BLK40;
    @(posedge CLK); #1;
    mem_busywait = 1'b1;
    @(posedge CLK); #1;
    PC = 32'h4C;
    #1;
    tests++;
    if (busywait !== 1'b0 || INSTRUCTION !== 32'h4000_0004) begin
      fails++;
      $display("FAIL pcchg_hit40: INSTRUCTION=%h busywait=%b required 40000004/0", INSTRUCTION, busywait);
    end
    PC = 32'h28;
    #1;
    tests++;
    if (busywait !== 1'b0 || INSTRUCTION !== 32'h2000_0003) begin
      fails++;
      $display("FAIL pcchg_hit20: INSTRUCTION=%h busywait=%b required 20000003/0", INSTRUCTION, busywait);
    end
    PC = 32'h14;
    #1;
    tests++;
    if (busywait !== 1'b0 || INSTRUCTION !== 32'h1000_0B0B) begin
      fails++;
      $display("FAIL pcchg_hit10: INSTRUCTION=%h busywait=%b required 10000b0b/0", INSTRUCTION, busywait);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_reset_mid_refill();
    test_pc_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
